// File: rtl/ifu.sv
// ifu -- instruction fetch stage of the RV32I 5-stage pipeline.
//
// Holds the fetch PC, issues fetches to instruction memory with at most one
// request outstanding, buffers one response while decode is stalled, drops
// wrong-path responses after a redirect and owns the IF/ID register.
//
// Handshake: a request transfers on a rising CLK edge where ImemReqValid and
// ImemReqReady are both 1. ImemReqValid only depends on registered state and
// the hazard/redirect inputs, never on ImemReqReady. ImemAddr is held stable
// while ImemReqValid=1 and the request has not transferred. A response is a
// single cycle with ImemRespValid=1 and has no backpressure.
//
// Ports:
//   CLK, RST_N               clock (rising edge), async active-low reset
//   StallF, StallD, FlushD   hazard unit controls
//   PCSrcE, PCTargetE        redirect from execute
//   ImemReqValid/Ready/Addr  fetch request channel
//   ImemRespValid/Rdata      fetch response channel
//   InstrD, PCD, PCPlus4D    IF/ID register outputs
//   ValidD                   IF/ID holds a real instruction (0 = bubble)
//   FsmState                 debug view of the fetch FSM (0 IDLE, 1 WAIT, 2 DROP)
//
// Optional: define IFU_PERF_EN to add FetchCount and BubbleCount outputs.

module ifu #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        ImemReqValid,
  input  logic        ImemReqReady,
  output logic [31:0] ImemAddr,
  input  logic        ImemRespValid,
  input  logic [31:0] ImemRdata,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD,
`ifdef IFU_PERF_EN
  output logic [31:0] FetchCount,
  output logic [31:0] BubbleCount,
`endif
  output logic [1:0]  FsmState
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pcf;
  logic [31:0] req_pc;
  logic        buf_valid;
  logic [31:0] buf_instr;
  logic [31:0] buf_pc;

  logic        req_fire;
  logic        resp_accept;
  logic        ifid_bubble;
  logic        ifid_from_buf;
  logic        ifid_from_resp;
  logic [31:0] target_aligned;

  assign target_aligned = PCTargetE & 32'hFFFF_FFFC;
  assign ImemAddr       = pcf & 32'hFFFF_FFFC;
  assign FsmState       = state;

  assign req_fire    = ImemReqValid & ImemReqReady;
  // A response is only kept when it belongs to the live request and no
  // redirect arrives in the same cycle.
  assign resp_accept = (state == S_WAIT) & ImemRespValid & ~PCSrcE;

  // IF/ID source selection; StallD overrides everything (hold).
  assign ifid_bubble    = ~StallD & (FlushD | PCSrcE | ~(buf_valid | resp_accept));
  assign ifid_from_buf  = ~StallD & ~FlushD & ~PCSrcE & buf_valid;
  assign ifid_from_resp = ~StallD & ~FlushD & ~PCSrcE & ~buf_valid & resp_accept;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (req_fire) state_nxt = S_WAIT;
      S_WAIT: begin
        if (ImemRespValid)  state_nxt = S_IDLE;
        else if (PCSrcE)    state_nxt = S_DROP;
      end
      S_DROP: if (ImemRespValid) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // Gated with RST_N so no request is presented while reset is held.
  always_comb begin
    ImemReqValid = 1'b0;
    if (RST_N && state == S_IDLE && !StallF && !buf_valid && !PCSrcE)
      ImemReqValid = 1'b1;
  end

  // ---------------- fetch PC and request PC ----------------
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pcf    <= RESET_PC;
      req_pc <= 32'h0;
    end else begin
      if (PCSrcE)        pcf <= target_aligned;
      else if (req_fire) pcf <= pcf + 32'd4;
      if (req_fire)      req_pc <= pcf;
    end
  end

  // ---------------- one-entry response buffer ----------------
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      buf_valid <= 1'b0;
      buf_instr <= 32'h0;
      buf_pc    <= 32'h0;
    end else if (PCSrcE) begin
      buf_valid <= 1'b0;
    end else if (resp_accept && (StallD || buf_valid)) begin
      buf_valid <= 1'b1;
      buf_instr <= ImemRdata;
      buf_pc    <= req_pc;
    end else if (ifid_from_buf) begin
      buf_valid <= 1'b0;
    end
  end

  // ---------------- IF/ID pipeline register ----------------
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      InstrD   <= NOP_INSTR;
      PCD      <= 32'h0;
      PCPlus4D <= 32'h0;
      ValidD   <= 1'b0;
    end else if (ifid_bubble) begin
      InstrD   <= NOP_INSTR;
      PCD      <= 32'h0;
      PCPlus4D <= 32'h0;
      ValidD   <= 1'b0;
    end else if (ifid_from_buf) begin
      InstrD   <= buf_instr;
      PCD      <= buf_pc;
      PCPlus4D <= buf_pc + 32'd4;
      ValidD   <= 1'b1;
    end else if (ifid_from_resp) begin
      InstrD   <= ImemRdata;
      PCD      <= req_pc;
      PCPlus4D <= req_pc + 32'd4;
      ValidD   <= 1'b1;
    end
  end

`ifdef IFU_PERF_EN
  // ---------------- performance counters ----------------
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      FetchCount  <= 32'h0;
      BubbleCount <= 32'h0;
    end else begin
      if (ifid_from_buf || ifid_from_resp) FetchCount  <= FetchCount + 32'd1;
      if (ifid_bubble)                     BubbleCount <= BubbleCount + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ifu.sv
// tb_ifu -- directed, table-driven bench for the instruction fetch stage.
// A small memory model answers each accepted request with mem_word(addr);
// each table row gives the inputs of one cycle plus the expected request
// outputs before the edge and the expected IF/ID contents after it.

module tb_ifu;

  localparam logic [31:0] RESET_PC  = 32'h0000_0100;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RST_N;
  always #5 CLK = ~CLK;

  logic        StallF, StallD, FlushD, PCSrcE;
  logic [31:0] PCTargetE;
  logic        ImemReqValid, ImemReqReady;
  logic [31:0] ImemAddr;
  logic        ImemRespValid;
  logic [31:0] ImemRdata;
  logic [31:0] InstrD, PCD, PCPlus4D;
  logic        ValidD;
  logic [1:0]  FsmState;
`ifdef IFU_PERF_EN
  logic [31:0] FetchCount, BubbleCount;
`endif

  ifu #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
    .CLK           (CLK),
    .RST_N         (RST_N),
    .StallF        (StallF),
    .StallD        (StallD),
    .FlushD        (FlushD),
    .PCSrcE        (PCSrcE),
    .PCTargetE     (PCTargetE),
    .ImemReqValid  (ImemReqValid),
    .ImemReqReady  (ImemReqReady),
    .ImemAddr      (ImemAddr),
    .ImemRespValid (ImemRespValid),
    .ImemRdata     (ImemRdata),
    .InstrD        (InstrD),
    .PCD           (PCD),
    .PCPlus4D      (PCPlus4D),
    .ValidD        (ValidD),
`ifdef IFU_PERF_EN
    .FetchCount    (FetchCount),
    .BubbleCount   (BubbleCount),
`endif
    .FsmState      (FsmState)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  // ---------------- memory model state ----------------
  logic        pend;
  logic [31:0] pend_addr;

  // ---------------- vector table ----------------
  typedef struct {
    logic        stallf, stalld, flushd, pcsrc;
    logic [31:0] tgt;
    logic        ready, resp_en;
    logic        exp_rv;
    logic [31:0] exp_addr;
    logic        exp_vd;
    logic [31:0] exp_pcd;
  } vec_t;

  function automatic vec_t mk(input logic sf, input logic sd, input logic fd,
                              input logic ps, input logic [31:0] tg,
                              input logic rdy, input logic re,
                              input logic rv, input logic [31:0] ad,
                              input logic vd, input logic [31:0] pc);
    vec_t v;
    v.stallf = sf; v.stalld = sd; v.flushd = fd; v.pcsrc = ps; v.tgt = tg;
    v.ready = rdy; v.resp_en = re; v.exp_rv = rv; v.exp_addr = ad;
    v.exp_vd = vd; v.exp_pcd = pc;
    return v;
  endfunction

  // ---------------- driver: one clock cycle, starting at a negedge ----------------
  task automatic run_cycle(input vec_t v, input string name);
    logic [31:0] exp_instr, exp_pc4;
    StallF       = v.stallf;
    StallD       = v.stalld;
    FlushD       = v.flushd;
    PCSrcE       = v.pcsrc;
    PCTargetE    = v.tgt;
    ImemReqReady = v.ready;
    if (pend && v.resp_en) begin
      ImemRespValid = 1'b1;
      ImemRdata     = mem_word(pend_addr);
      pend          = 1'b0;
    end else begin
      ImemRespValid = 1'b0;
      ImemRdata     = 32'h0;
    end
    #1;
    chk({name, "_reqvalid"}, {31'h0, ImemReqValid}, {31'h0, v.exp_rv});
    chk({name, "_addr"}, ImemAddr, v.exp_addr);
    if (ImemReqValid && ImemReqReady) begin
      pend      = 1'b1;
      pend_addr = ImemAddr;
    end
    @(posedge CLK);
    #1;
    exp_instr = v.exp_vd ? mem_word(v.exp_pcd) : NOP_INSTR;
    exp_pc4   = v.exp_vd ? v.exp_pcd + 32'd4 : 32'h0;
    chk({name, "_validd"}, {31'h0, ValidD}, {31'h0, v.exp_vd});
    chk({name, "_pcd"}, PCD, v.exp_pcd);
    chk({name, "_pcplus4d"}, PCPlus4D, exp_pc4);
    chk({name, "_instrd"}, InstrD, exp_instr);
    @(negedge CLK);
  endtask

  vec_t vecs[28];

  initial begin
    // ---------------- reset ----------------
    RST_N = 1'b0;
    StallF = 0; StallD = 0; FlushD = 0; PCSrcE = 0; PCTargetE = 32'h0;
    ImemReqReady = 0; ImemRespValid = 0; ImemRdata = 32'h0;
    pend = 0; pend_addr = 32'h0;
    repeat (3) @(negedge CLK);
    chk("rst_validd", {31'h0, ValidD}, 32'h0);
    chk("rst_instrd", InstrD, NOP_INSTR);
    chk("rst_pcd", PCD, 32'h0);
    chk("rst_pcplus4d", PCPlus4D, 32'h0);
    chk("rst_reqvalid", {31'h0, ImemReqValid}, 32'h0);
    chk("rst_addr", ImemAddr, RESET_PC);
    chk("rst_state", {30'h0, FsmState}, 32'h0);
    RST_N = 1'b1;

    //            sf sd fd ps tgt           rdy re  rv addr           vd pcd
    // steady fetch from RESET_PC, one instruction every two cycles
    vecs[0]  = mk(0, 0, 0, 0, 32'h0,        1, 1,  1, 32'h0000_0100, 0, 32'h0);
    vecs[1]  = mk(0, 0, 0, 0, 32'h0,        1, 1,  0, 32'h0000_0104, 1, 32'h0000_0100);
    vecs[2]  = mk(0, 0, 0, 0, 32'h0,        1, 1,  1, 32'h0000_0104, 0, 32'h0);
    vecs[3]  = mk(0, 0, 0, 0, 32'h0,        1, 1,  0, 32'h0000_0108, 1, 32'h0000_0104);
    // StallD for 3 cycles while 0x108 returns: IF/ID holds, buffer captures
    vecs[4]  = mk(0, 1, 0, 0, 32'h0,        1, 1,  1, 32'h0000_0108, 1, 32'h0000_0104);
    vecs[5]  = mk(0, 1, 0, 0, 32'h0,        1, 1,  0, 32'h0000_010C, 1, 32'h0000_0104);
    vecs[6]  = mk(0, 1, 0, 0, 32'h0,        1, 1,  0, 32'h0000_010C, 1, 32'h0000_0104);
    vecs[7]  = mk(0, 0, 0, 0, 32'h0,        1, 1,  0, 32'h0000_010C, 1, 32'h0000_0108);
    vecs[8]  = mk(0, 0, 0, 0, 32'h0,        1, 1,  1, 32'h0000_010C, 0, 32'h0);
    // redirect in WAIT with no response -> DROP, stale response dropped
    vecs[9]  = mk(0, 0, 0, 1, 32'h0000_0203, 1, 0, 0, 32'h0000_0110, 0, 32'h0);
    vecs[10] = mk(0, 0, 0, 0, 32'h0,        1, 1,  0, 32'h0000_0200, 0, 32'h0);
    vecs[11] = mk(0, 0, 0, 0, 32'h0,        1, 1,  1, 32'h0000_0200, 0, 32'h0);
    // redirect in the same cycle as the response
    vecs[12] = mk(0, 0, 0, 1, 32'h0000_0300, 1, 1, 0, 32'h0000_0204, 0, 32'h0);
    // memory not ready for 4 cycles: request and address held
    vecs[13] = mk(0, 0, 0, 0, 32'h0,        0, 1,  1, 32'h0000_0300, 0, 32'h0);
    vecs[14] = mk(0, 0, 0, 0, 32'h0,        0, 1,  1, 32'h0000_0300, 0, 32'h0);
    vecs[15] = mk(0, 0, 0, 0, 32'h0,        0, 1,  1, 32'h0000_0300, 0, 32'h0);
    vecs[16] = mk(0, 0, 0, 0, 32'h0,        0, 1,  1, 32'h0000_0300, 0, 32'h0);
    vecs[17] = mk(0, 0, 0, 0, 32'h0,        1, 1,  1, 32'h0000_0300, 0, 32'h0);
    vecs[18] = mk(0, 0, 0, 0, 32'h0,        1, 1,  0, 32'h0000_0304, 1, 32'h0000_0300);
    // FlushD while the response arrives: bubble wins
    vecs[19] = mk(0, 0, 0, 0, 32'h0,        1, 1,  1, 32'h0000_0304, 0, 32'h0);
    vecs[20] = mk(0, 0, 1, 0, 32'h0,        1, 1,  0, 32'h0000_0308, 0, 32'h0);
    // StallF suppresses the request
    vecs[21] = mk(1, 0, 0, 0, 32'h0,        1, 1,  0, 32'h0000_0308, 0, 32'h0);
    vecs[22] = mk(0, 0, 0, 0, 32'h0,        1, 1,  1, 32'h0000_0308, 0, 32'h0);
    vecs[23] = mk(0, 0, 0, 0, 32'h0,        1, 1,  0, 32'h0000_030C, 1, 32'h0000_0308);
    // PC wrap from 0xFFFFFFFC to 0
    vecs[24] = mk(0, 0, 0, 1, 32'hFFFF_FFFE, 1, 1, 0, 32'h0000_030C, 0, 32'h0);
    vecs[25] = mk(0, 0, 0, 0, 32'h0,        1, 1,  1, 32'hFFFF_FFFC, 0, 32'h0);
    vecs[26] = mk(0, 0, 0, 0, 32'h0,        1, 1,  0, 32'h0000_0000, 1, 32'hFFFF_FFFC);
    // issue a request while decode holds a valid instruction (ends in WAIT)
    vecs[27] = mk(0, 1, 0, 0, 32'h0,        1, 1,  1, 32'h0000_0000, 1, 32'hFFFF_FFFC);

    @(negedge CLK);
    for (int i = 0; i < 28; i++) run_cycle(vecs[i], $sformatf("v%0d", i));

    // ---------------- reset asserted mid-WAIT ----------------
    chk("wait_state", {30'h0, FsmState}, 32'h1);
    ImemRespValid = 1'b0;
    StallD        = 1'b0;
    #2;
    RST_N = 1'b0;
    #1;
    chk("arst_validd", {31'h0, ValidD}, 32'h0);
    chk("arst_instrd", InstrD, NOP_INSTR);
    chk("arst_pcd", PCD, 32'h0);
    chk("arst_pcplus4d", PCPlus4D, 32'h0);
    chk("arst_reqvalid", {31'h0, ImemReqValid}, 32'h0);
    chk("arst_addr", ImemAddr, RESET_PC);
    chk("arst_state", {30'h0, FsmState}, 32'h0);
    @(negedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    // the stale response (for address 0) lands in IDLE and must be ignored
    run_cycle(mk(0, 0, 0, 0, 32'h0, 1, 1, 1, 32'h0000_0100, 0, 32'h0), "post_rst0");
    run_cycle(mk(0, 0, 0, 0, 32'h0, 1, 1, 0, 32'h0000_0104, 1, 32'h0000_0100), "post_rst1");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ifu.md
Name: ifu

Overview:
- Instruction fetch stage of the RV32I 5-stage pipeline. Directly upstream of the decode stage; it drives that stage's InstrD, PCD and PCPlus4D inputs.
- Holds the fetch PC and issues one-outstanding-request fetches to instruction memory over a valid/ready request, valid-only response interface.
- Buffers one response while decode is stalled, discards wrong-path responses after a redirect, and owns the IF/ID pipeline register.

Parameters:
- RESET_PC, 32'h00000000, PC fetched first after reset.
- NOP_INSTR, 32'h00000013, instruction (addi x0,x0,0) injected as a bubble.

Ports:
- CLK  in  1  clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- StallF  in  1  hazard unit: do not issue a new fetch request.
- StallD  in  1  hazard unit: hold the IF/ID register.
- FlushD  in  1  hazard unit: load a bubble into IF/ID.
- PCSrcE  in  1  redirect from execute (taken branch, jal or jalr).
- PCTargetE  in  32  redirect target.
- ImemReqValid  out  1  fetch request valid.
- ImemReqReady  in  1  memory accepts the request.
- ImemAddr  out  32  word-aligned fetch address.
- ImemRespValid  in  1  response data valid; no backpressure.
- ImemRdata  in  32  fetched instruction.
- InstrD  out  32  IF/ID instruction.
- PCD  out  32  IF/ID PC.
- PCPlus4D  out  32  IF/ID PC+4.
- ValidD  out  1  IF/ID holds a real instruction (0 = bubble).

Behaviour:
- Async reset (RST_N=0):
  - PCF=RESET_PC, state=IDLE, buffer empty, ImemReqValid=0.
  - InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, ValidD=0.
- ImemReqValid and ImemAddr are combinational from registered state. ImemAddr={PCF[31:2],2'b00}.
- States:
  - IDLE: nothing outstanding. ImemReqValid=1 when !StallF, the buffer is empty and PCSrcE=0. If ImemReqReady is also 1: latch reqPC=PCF, set PCF<=PCF+4 (mod 2^32), go to WAIT.
  - WAIT: one request outstanding, ImemReqValid=0.
    - ImemRespValid=1 with PCSrcE=0: the response is accepted; go to IDLE.
    - ImemRespValid=1 with PCSrcE=1: the response is discarded; go to IDLE.
    - ImemRespValid=0 with PCSrcE=1: go to DROP.
  - DROP: wrong-path request outstanding, ImemReqValid=0. ImemRespValid=1 discards the data and goes to IDLE.
- Redirect: PCSrcE=1 in any state sets PCF<={PCTargetE[31:2],2'b00} and clears the buffer. Redirect has priority over request issue and StallF.
- Accepted response routing:
  - If StallD=0 and the buffer is empty, it is written straight into IF/ID.
  - Otherwise it goes into the 1-entry buffer as {instr, reqPC}.
- IF/ID update, in priority order:
  1. StallD=1: hold all four registers (FlushD is ignored while StallD=1).
  2. FlushD=1 or PCSrcE=1: load a bubble (InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, ValidD=0).
  3. Buffer full: load the buffer entry and empty the buffer.
  4. Response accepted this cycle: load {ImemRdata, reqPC, reqPC+4}, ValidD=1.
  5. Otherwise: load a bubble.
- Latency: request accepted in cycle N, response in N+1, InstrD valid after edge N+1. With a single outstanding request the peak rate is one instruction every 2 cycles.
- Boundaries:
  - A response while the buffer is full cannot occur, because no request is issued while the buffer is non-empty.
  - PC wraps from 0xFFFFFFFC to 0x00000000.
  - Reset mid-WAIT abandons the request. A stale response arriving after reset in IDLE is ignored.

Optional Feature:
- Macro IFU_PERF_EN.
- Defined: adds output ports FetchCount[31:0] and BubbleCount[31:0], both reset to 0.
  - FetchCount +1 each cycle IF/ID loads ValidD=1.
  - BubbleCount +1 each cycle IF/ID loads a bubble while StallD=0.
  - Both wrap at 2^32.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, RESET_PC=0x100, memory always ready with 1-cycle response -> first ImemAddr=0x100; InstrD/PCD/PCPlus4D sequence 0x100/0x104, 0x104/0x108 …, ValidD alternating 1,0.
- StallD held 3 cycles while a response for 0x108 arrives -> IF/ID holds its prior value, buffer captures 0x108, no new request; after release InstrD=mem[0x108], PCD=0x108.
- PCSrcE=1, PCTargetE=0x203 in WAIT with no response -> DROP; next response dropped; next ImemAddr=0x200; IF/ID shows a bubble.
- PCSrcE=1 in the same cycle as ImemRespValid -> data discarded, next request at the target, ValidD=0 that cycle.
- ImemReqReady held low 4 cycles -> ImemReqValid stays 1 and ImemAddr stays stable; PCF does not advance.
- RST_N asserted mid-WAIT -> all outputs return to reset values immediately (async); the late response is ignored; fetch restarts at RESET_PC.
